// File: rtl/aes128_package.sv
// Shared types for the masked AES S-box datapath, including the Frobenius power unit.
package aes128_package;

  typedef logic [1:0] bv2_t;
  typedef logic [3:0] bv4_t;

  localparam int FROB_COEF_W     = 2;
  localparam int FROB_NUM_COEF   = 2;
  localparam int FROB_NUM_SHARES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    HOLD = 2'd2
  } frob_state_t;

  // Exponent width is max(1, clog2(num_coef)) so a 2-coefficient element still gets one bit.
  function automatic int frob_exp_w(input int num_coef);
    return (num_coef > 2) ? $clog2(num_coef) : 1;
  endfunction

endpackage

// File: rtl/bv_coef_rot.sv
// Single-step cyclic rotation of one share: coefficient i moves to slot (i+1) mod NUM_COEF.
module bv_coef_rot
  import aes128_package::*;
#(
  parameter int COEF_W   = FROB_COEF_W,
  parameter int NUM_COEF = FROB_NUM_COEF
) (
  input  logic [NUM_COEF*COEF_W-1:0] in_v,
  output logic [NUM_COEF*COEF_W-1:0] out_v
);

  assign out_v = {in_v[(NUM_COEF-1)*COEF_W-1:0], in_v[NUM_COEF*COEF_W-1 -: COEF_W]};

endmodule

// File: rtl/bv_frob_iter.sv
// Iterative share-wise Frobenius power a^(q^e): one coefficient rotation per cycle.
// Optional macro FROB_REFRESH_EN adds in_random and remasks shares 0 and NUM_SHARES-1 on load.
module bv_frob_iter
  import aes128_package::*;
#(
  parameter  int NUM_SHARES = FROB_NUM_SHARES,
  parameter  int COEF_W     = FROB_COEF_W,
  parameter  int NUM_COEF   = FROB_NUM_COEF,
  localparam int ELEM_W     = NUM_COEF * COEF_W,
  localparam int EXP_W      = frob_exp_w(NUM_COEF)
) (
  input  logic                               in_clock,
  input  logic                               in_reset_n,
  input  logic                               in_valid,
  output logic                               out_ready,
  input  logic [NUM_SHARES-1:0][ELEM_W-1:0]  in_a,
  input  logic [EXP_W-1:0]                   in_exp,
`ifdef FROB_REFRESH_EN
  input  logic [ELEM_W-1:0]                  in_random,
`endif
  output logic                               out_valid,
  input  logic                               in_ready,
  output logic [NUM_SHARES-1:0][ELEM_W-1:0]  out_b
);

  if (NUM_COEF < 2) begin : g_bad_num_coef
    $error("bv_frob_iter: NUM_COEF must be at least 2");
  end

`ifdef FROB_REFRESH_EN
  if (NUM_SHARES < 2) begin : g_bad_num_shares
    $error("bv_frob_iter: FROB_REFRESH_EN needs at least 2 shares");
  end
`endif

  frob_state_t                       state_q, state_d;
  logic [EXP_W-1:0]                  cnt_q, cnt_d;
  logic [NUM_SHARES-1:0][ELEM_W-1:0] data_q, data_d;
  logic                              valid_q, valid_d;
  logic                              ready_q, ready_d;

  logic [NUM_SHARES-1:0][ELEM_W-1:0] load_v;
  logic [NUM_SHARES-1:0][ELEM_W-1:0] rot_v;
  logic [EXP_W-1:0]                  exp_red;

  // Power-of-two NUM_COEF already fits in_exp exactly; otherwise reduce by the constant modulus.
  if ((NUM_COEF & (NUM_COEF - 1)) == 0) begin : g_exp_pow2
    assign exp_red = in_exp;
  end else begin : g_exp_mod
    localparam logic [EXP_W-1:0] NUM_COEF_E = EXP_W'(NUM_COEF);
    assign exp_red = in_exp % NUM_COEF_E;
  end

  for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
`ifdef FROB_REFRESH_EN
    if (s == 0 || s == NUM_SHARES - 1) begin : g_refresh
      assign load_v[s] = in_a[s] ^ in_random;
    end else begin : g_plain
      assign load_v[s] = in_a[s];
    end
`else
    assign load_v[s] = in_a[s];
`endif

    bv_coef_rot #(
      .COEF_W   (COEF_W),
      .NUM_COEF (NUM_COEF)
    ) u_rot (
      .in_v  (data_q[s]),
      .out_v (rot_v[s])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = load_v;
          cnt_d   = exp_red;
          state_d = (exp_red != '0) ? ROT : HOLD;
        end
      end
      ROT: begin
        data_d = rot_v;
        cnt_d  = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (in_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so every output comes from a flop.
  assign valid_d = (state_d == HOLD);
  assign ready_d = (state_d == IDLE);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign out_b     = data_q;
  assign out_valid = valid_q;
  assign out_ready = ready_q;

endmodule

// File: tb/tb_bv_frob_iter.sv
// Bench for bv_frob_iter: a 2-coefficient and a 3-coefficient instance against a transaction-level model.
module tb_bv_frob_iter;

  localparam int CW = 2;
  localparam int NS = 2;
  localparam int NA = 2;
  localparam int NB = 3;
  localparam int WA = NA * CW;
  localparam int WB = NB * CW;
  localparam int EA = 1;
  localparam int EB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;

  logic va = 1'b0, ra = 1'b0, vb = 1'b0, rb = 1'b0;
  logic [NS-1:0][WA-1:0] a_a = '0;
  logic [NS-1:0][WB-1:0] a_b = '0;
  logic [EA-1:0] e_a = '0;
  logic [EB-1:0] e_b = '0;
  logic [WA-1:0] rnd_a = '0;
  logic [WB-1:0] rnd_b = '0;

  logic rdy_a, val_a, rdy_b, val_b;
  logic [NS-1:0][WA-1:0] b_a;
  logic [NS-1:0][WB-1:0] b_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bv_frob_iter #(.NUM_SHARES(NS), .COEF_W(CW), .NUM_COEF(NA)) dut_a (
    .in_clock(clk), .in_reset_n(rst_n), .in_valid(va), .out_ready(rdy_a),
    .in_a(a_a), .in_exp(e_a),
`ifdef FROB_REFRESH_EN
    .in_random(rnd_a),
`endif
    .out_valid(val_a), .in_ready(ra), .out_b(b_a)
  );

  bv_frob_iter #(.NUM_SHARES(NS), .COEF_W(CW), .NUM_COEF(NB)) dut_b (
    .in_clock(clk), .in_reset_n(rst_n), .in_valid(vb), .out_ready(rdy_b),
    .in_a(a_b), .in_exp(e_b),
`ifdef FROB_REFRESH_EN
    .in_random(rnd_b),
`endif
    .out_valid(val_b), .in_ready(rb), .out_b(b_b)
  );

  // Uniform views of both instances so one model and one checker can serve both.
  logic        iv [2];
  logic        ir [2];
  int          ie [2];
  logic [63:0] ia [2][NS];
  logic [63:0] irnd [2];
  logic        ov [2];
  logic        ordy [2];
  logic [63:0] ob [2][NS];

  always_comb begin
    iv[0] = va;  iv[1] = vb;
    ir[0] = ra;  ir[1] = rb;
    ie[0] = int'(e_a);  ie[1] = int'(e_b);
    irnd[0] = 64'(rnd_a);  irnd[1] = 64'(rnd_b);
    ov[0] = val_a;  ov[1] = val_b;
    ordy[0] = rdy_a;  ordy[1] = rdy_b;
    for (int s = 0; s < NS; s++) begin
      ia[0][s] = 64'(a_a[s]);
      ia[1][s] = 64'(a_b[s]);
      ob[0][s] = 64'(b_a[s]);
      ob[1][s] = 64'(b_b[s]);
    end
  end

  function automatic int ncoef(input int k);
    return (k == 0) ? NA : NB;
  endfunction

  // a^(q^e) in a normal basis: output coefficient i is input coefficient (i - e) mod n.
  function automatic logic [63:0] frob(input logic [63:0] v, input int e, input int n);
    logic [63:0] r;
    int src;
    r = '0;
    for (int i = 0; i < n; i++) begin
      src = (((i - e) % n) + n) % n;
      r[i*CW +: CW] = v[src*CW +: CW];
    end
    return r;
  endfunction

  function automatic logic [63:0] loaded(input int k, input int s);
    logic [63:0] v;
    v = ia[k][s];
`ifdef FROB_REFRESH_EN
    if (s == 0 || s == NS - 1) v = v ^ irnd[k];
`endif
    return v;
  endfunction

  logic        m_ready [2] = '{1'b1, 1'b1};
  logic        m_valid [2] = '{1'b0, 1'b0};
  int          m_left  [2] = '{0, 0};
  logic [63:0] m_res   [2][NS];

  // Transaction model: accept when free, count down e mod n cycles, then hold until taken.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ready[k] <= 1'b1;
        m_valid[k] <= 1'b0;
        m_left[k]  <= 0;
      end else if (m_ready[k]) begin
        if (iv[k]) begin
          m_ready[k] <= 1'b0;
          m_left[k]  <= ie[k] % ncoef(k);
          m_valid[k] <= ((ie[k] % ncoef(k)) == 0);
          for (int s = 0; s < NS; s++) m_res[k][s] <= frob(loaded(k, s), ie[k], ncoef(k));
        end
      end else if (!m_valid[k]) begin
        m_left[k] <= m_left[k] - 1;
        if (m_left[k] == 1) m_valid[k] <= 1'b1;
      end else if (ir[k]) begin
        m_valid[k] <= 1'b0;
        m_ready[k] <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          checkOutput($sformatf("ready[%0d]", k), 64'(ordy[k]), 64'(m_ready[k]));
          checkOutput($sformatf("valid[%0d]", k), 64'(ov[k]), 64'(m_valid[k]));
          if (m_valid[k]) begin
            for (int s = 0; s < NS; s++)
              checkOutput($sformatf("b[%0d][%0d]", k, s), ob[k][s], m_res[k][s]);
          end
        end
      end
    end
  end

  task automatic waitReadyA();
    int t = 0;
    while (!rdy_a && t < 20) begin @(posedge clk); #1; t++; end
    checkOutput("idle_a", 64'(rdy_a), 64'd1);
  endtask

  task automatic waitReadyB();
    int t = 0;
    while (!rdy_b && t < 20) begin @(posedge clk); #1; t++; end
    checkOutput("idle_b", 64'(rdy_b), 64'd1);
  endtask

  task automatic applyStimulusA(input logic [WA-1:0] s0, input logic [WA-1:0] s1, input logic [EA-1:0] e,
                                input int exp_lat, input logic [2*WA-1:0] exp_b);
    int lat;
    waitReadyA();
    va = 1'b1; a_a[0] = s0; a_a[1] = s1; e_a = e; ra = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    lat = 1;
    while (!val_a && lat < 10) begin @(posedge clk); #1; lat++; end
    checkOutput("lat_a", 64'(lat), 64'(exp_lat));
    checkOutput("data_a", 64'(b_a), 64'(exp_b));
  endtask

  task automatic applyStimulusB(input logic [WB-1:0] s0, input logic [WB-1:0] s1, input logic [EB-1:0] e,
                                input int exp_lat, input logic [2*WB-1:0] exp_b);
    int lat;
    waitReadyB();
    vb = 1'b1; a_b[0] = s0; a_b[1] = s1; e_b = e; rb = 1'b1;
    @(posedge clk); #1;
    vb = 1'b0;
    lat = 1;
    while (!val_b && lat < 10) begin @(posedge clk); #1; lat++; end
    checkOutput("lat_b", 64'(lat), 64'(exp_lat));
    checkOutput("data_b", 64'(b_b), 64'(exp_b));
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready_a", 64'(rdy_a), 64'd1);
    checkOutput("rst_valid_a", 64'(val_a), 64'd0);
    checkOutput("rst_data_a", 64'(b_a), 64'd0);
    checkOutput("rst_data_b", 64'(b_b), 64'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Single rotation, then identity; shares {0110,1101}.
    applyStimulusA(4'b1101, 4'b0110, 1'b1, 2, 8'h97);
    applyStimulusA(4'b1101, 4'b0110, 1'b0, 1, 8'h6D);
    // Three coefficients: e=3 reduces to identity, e=2 rotates twice.
    applyStimulusB(6'h27, 6'h15, 2'd3, 1, 12'h567);
    applyStimulusB(6'h27, 6'h15, 2'd2, 3, 12'h579);

    // Downstream stall: result must sit still with out_ready low.
    waitReadyA();
    va = 1'b1; a_a[0] = 4'b1101; a_a[1] = 4'b0110; e_a = 1'b1; ra = 1'b0;
    @(posedge clk); #1;
    va = 1'b0;
    t = 0;
    while (!val_a && t < 10) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", 64'(val_a), 64'd1);
      checkOutput("stall_ready", 64'(rdy_a), 64'd0);
      checkOutput("stall_data", 64'(b_a), 64'h97);
      @(posedge clk); #1;
    end
    ra = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_ready", 64'(rdy_a), 64'd1);

    // Reset in the middle of a rotation clears everything at once.
    waitReadyB();
    vb = 1'b1; a_b[0] = 6'h27; a_b[1] = 6'h15; e_b = 2'd2; rb = 1'b1;
    @(posedge clk); #1;
    vb = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrot_valid", 64'(val_b), 64'd0);
    checkOutput("midrot_data", 64'(b_b), 64'd0);
    checkOutput("midrot_ready", 64'(rdy_b), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulusB(6'h27, 6'h15, 2'd2, 3, 12'h579);

`ifdef FROB_REFRESH_EN
    // Remasked shares {1100,0111} rotate to {0011,1101}; their XOR still equals the rotated secret.
    rnd_a = 4'hA;
    applyStimulusA(4'b1101, 4'b0110, 1'b1, 2, 8'h3D);
    checkOutput("unmasked_a", 64'(b_a[0] ^ b_a[1]), 64'hE);
`endif

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      va = ($urandom_range(3) != 0);
      vb = ($urandom_range(3) != 0);
      ra = ($urandom_range(2) != 0);
      rb = ($urandom_range(2) != 0);
      a_a = (2*WA)'($urandom);
      a_b = (2*WB)'($urandom);
      e_a = EA'($urandom);
      e_b = EB'($urandom);
      rnd_a = WA'($urandom);
      rnd_b = WB'($urandom);
    end
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
